reset_sequencer: RTL and testbench

- Central reset controller for the async-assert / sync-deassert flop style used across the design.
- Takes the board reset rst_n and a PLL lock indication and releases N_OUT downstream reset domains one at a time, in fixed order, STEP_CYCLES apart.
- Supports a software-requested re-reset and re-sequence.
- Sits at top level; each rst_out_n[k] drives the rst_n pins of one domain's flops.

---
 rtl/reset_sequencer.sv | 148 ++++++++++++++
 tb/tb_reset_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - central reset sequencer releasing N_OUT domain resets in fixed order
module reset_sequencer #(
    parameter int N_OUT       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STEP_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic [N_OUT-1:0] rst_out_n,
    output logic             seq_done,
    output logic             busy
);

    // idx counts up to N_OUT without wrapping, so it needs one extra bit
    localparam int IDX_W = $clog2(N_OUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2,
        S_SOFT  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             lock_q;
    logic                   rst_sync_n;
    logic                   locked_s;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [N_OUT-1:0]       rst_out_q;
    logic                   seq_done_q;
    logic                   busy_q;

    // Reset-deassert synchroniser: clears instantly, fills with ones one edge at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= 2'b00;
        end else begin
            lock_q <= {lock_q[0], pll_locked};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];
    assign locked_s   = lock_q[1];

    // Sequencing FSM: waits for reset+lock, releases one domain per step, re-resets on request or lock loss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_out_q  <= '0;
            seq_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    rst_out_q  <= '0;
                    seq_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                    if (rst_sync_n && locked_s) begin
                        state_q <= S_COUNT;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_COUNT: begin
                    // A re-reset takes priority over a release landing on the same edge
                    if (soft_rst_req || !locked_s) begin
                        state_q    <= S_SOFT;
                        rst_out_q  <= '0;
                        seq_done_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + IDX_W'(1);
                        for (int k = 0; k < N_OUT; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                rst_out_q[k] <= 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_q    <= S_DONE;
                            seq_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (soft_rst_req || !locked_s) begin
                        state_q    <= S_SOFT;
                        rst_out_q  <= '0;
                        seq_done_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        idx_q      <= '0;
                    end
                end
                S_SOFT: begin
                    // Hold all domains in reset for one step; requests arriving here are dropped
                    rst_out_q  <= '0;
                    seq_done_q <= 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= S_HOLD;
                    cnt_q      <= '0;
                    idx_q      <= '0;
                    rst_out_q  <= '0;
                    seq_done_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out_n = rst_out_q;
    assign seq_done  = seq_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer release timing and re-reset paths
module tb_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_rst_req;
    logic [3:0] rst_out_n;
    logic       seq_done;
    logic       busy;

    reset_sequencer #(
        .N_OUT      (4),
        .SYNC_STAGES(2),
        .STEP_CYCLES(16),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .soft_rst_req(soft_rst_req),
        .rst_out_n   (rst_out_n),
        .seq_done    (seq_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         e;
        logic [3:0] out;
        logic       done;
        logic       bsy;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   total  = 0;
    int   passed = 0;

    function automatic void push(input int e, input logic [3:0] out, input logic done,
                                 input logic bsy, input string tag);
        exp_t x;
        x.e = e; x.out = out; x.done = done; x.bsy = bsy; x.tag = tag;
        sb.push_back(x);
    endfunction

    task automatic check_now(input string tag, input logic [3:0] out, input logic done,
                             input logic bsy);
        total++;
        assert (rst_out_n === out && seq_done === done && busy === bsy) passed++;
        else $error("FAIL %s edge %0d: got out=%b done=%b busy=%b, want out=%b done=%b busy=%b",
                    tag, edge_n, rst_out_n, seq_done, busy, out, done, bsy);
    endtask

    task automatic tick();
        exp_t x;
        @(posedge clk);
        edge_n++;
        #1;
        while (sb.size() > 0 && sb[0].e <= edge_n) begin
            x = sb.pop_front();
            total++;
            assert (x.e == edge_n && rst_out_n === x.out && seq_done === x.done && busy === x.bsy)
                passed++;
            else $error("FAIL %s edge %0d (due %0d): got out=%b done=%b busy=%b, want out=%b done=%b busy=%b",
                        x.tag, edge_n, x.e, rst_out_n, seq_done, busy, x.out, x.done, x.bsy);
        end
    endtask

    task automatic run_until(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic soft_pulse();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic push_powerup(input string p);
        push(2,  4'b0000, 1'b0, 1'b0, {p, "_hold2"});
        push(3,  4'b0000, 1'b0, 1'b1, {p, "_count3"});
        push(18, 4'b0000, 1'b0, 1'b1, {p, "_pre19"});
        push(19, 4'b0001, 1'b0, 1'b1, {p, "_rel0"});
        push(34, 4'b0001, 1'b0, 1'b1, {p, "_pre35"});
        push(35, 4'b0011, 1'b0, 1'b1, {p, "_rel1"});
        push(51, 4'b0111, 1'b0, 1'b1, {p, "_rel2"});
        push(66, 4'b0111, 1'b0, 1'b1, {p, "_pre67"});
        push(67, 4'b1111, 1'b1, 1'b0, {p, "_rel3_done"});
        push(70, 4'b1111, 1'b1, 1'b0, {p, "_done_hold"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;
        #12;
        check_now("reset_state", 4'b0000, 1'b0, 1'b0);

        // Power-up with lock already present
        release_reset();
        push_powerup("pwr");
        run_until(70);

        // Soft reset in DONE (N=71), then a soft request on bit 1's release edge (120)
        push(71,  4'b0000, 1'b0, 1'b1, "soft_entry");
        push(86,  4'b0000, 1'b0, 1'b1, "soft_hold_end");
        push(87,  4'b0000, 1'b0, 1'b0, "soft_to_hold");
        push(88,  4'b0000, 1'b0, 1'b1, "soft_recount");
        push(103, 4'b0000, 1'b0, 1'b1, "soft_pre_rel0");
        push(104, 4'b0001, 1'b0, 1'b1, "soft_rel0");
        push(119, 4'b0001, 1'b0, 1'b1, "coin_pre");
        push(120, 4'b0000, 1'b0, 1'b1, "coin_soft_wins");
        push(121, 4'b0000, 1'b0, 1'b1, "coin_no_rise");
        push(136, 4'b0000, 1'b0, 1'b0, "coin_to_hold");
        push(137, 4'b0000, 1'b0, 1'b1, "coin_recount");
        push(153, 4'b0001, 1'b0, 1'b1, "coin_rel0");
        push(169, 4'b0011, 1'b0, 1'b1, "coin_rel1");
        // Lock loss sampled at edge M=175
        push(176, 4'b0011, 1'b0, 1'b1, "lol_m1");
        push(177, 4'b0000, 1'b0, 1'b1, "lol_m2_soft");
        push(192, 4'b0000, 1'b0, 1'b1, "lol_soft_end");
        push(193, 4'b0000, 1'b0, 1'b0, "lol_hold");
        push(220, 4'b0000, 1'b0, 1'b0, "lol_wait");
        push(222, 4'b0000, 1'b0, 1'b0, "relock_sync");
        push(223, 4'b0000, 1'b0, 1'b1, "relock_count");
        push(239, 4'b0001, 1'b0, 1'b1, "relock_rel0");
        push(271, 4'b0111, 1'b0, 1'b1, "relock_rel2");
        push(280, 4'b0111, 1'b0, 1'b1, "pre_async");

        soft_pulse();
        run_until(119);
        soft_pulse();
        run_until(174);
        pll_locked = 1'b0;
        run_until(220);
        pll_locked = 1'b1;
        run_until(280);

        // Async reset mid-sequence at 0111, then the power-up timing again
        rst_n = 1'b0;
        #1;
        check_now("async_clear", 4'b0000, 1'b0, 1'b0);
        release_reset();
        push_powerup("rerun");
        run_until(70);

        // Late lock; a soft request while in HOLD is dropped
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        #1;
        check_now("async_clear_done", 4'b0000, 1'b0, 1'b0);
        release_reset();
        push(21, 4'b0000, 1'b0, 1'b0, "hold_soft_ignored");
        push(40, 4'b0000, 1'b0, 1'b0, "late_wait");
        push(42, 4'b0000, 1'b0, 1'b0, "late_sync");
        push(43, 4'b0000, 1'b0, 1'b1, "late_count");
        push(58, 4'b0000, 1'b0, 1'b1, "late_pre_rel0");
        push(59, 4'b0001, 1'b0, 1'b1, "late_rel0");
        run_until(20);
        soft_pulse();
        run_until(40);
        pll_locked = 1'b1;
        run_until(60);

        total++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
